// File: rtl/reservation_station_pkg.sv
// Shared structs, widths and constants for the reservation station slice.
// The CDB capture helper lives here so the entry update and the issue
// path apply exactly the same operand-forwarding rule.
package reservation_station_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  // Tag value meaning "operand already present, nothing to wait for"
  localparam logic [TAG_W-1:0] RS_NO_TAG = 4'hF;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } rs_scheduler_s;

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } register_status_s;

  // Per-entry lifecycle; WAITING and READY share BUSY and differ only in tags
  typedef enum logic {
    ENTRY_FREE = 1'b0,
    ENTRY_BUSY = 1'b1
  } entry_state_e;

  // Replace any source operand still waiting on the broadcast tag
  function automatic rs_scheduler_s cdb_capture(
    input rs_scheduler_s     e,
    input logic              cdbValid,
    input logic [TAG_W-1:0]  cdbTag,
    input logic [DATA_W-1:0] cdbValue,
    input logic [TAG_W-1:0]  noTag
  );
    rs_scheduler_s res;
    res = e;
    if (cdbValid && (e.qj == cdbTag) && (e.qj != noTag)) begin
      res.vj = cdbValue;
      res.qj = noTag;
    end
    if (cdbValid && (e.qk == cdbTag) && (e.qk != noTag)) begin
      res.vk = cdbValue;
      res.qk = noTag;
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// rs_select: picks one ready entry for dispatch.
// Default build picks the lowest-index ready entry and holds no state.
// With RS_OLDEST_FIRST_EN defined, an age matrix picks the entry issued
// earliest; r_older[a][b]=1 means entry a was issued before entry b.
module rs_select
  import reservation_station_pkg::*;
#(
  parameter int N = 8
) (
`ifdef RS_OLDEST_FIRST_EN
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 i_flush,
  input  logic                 i_allocValid,
  input  logic [$clog2(N)-1:0] i_allocIdx,
  input  logic [N-1:0]         i_busy,
`endif
  input  logic [N-1:0]         i_ready,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_index,
  output logic                 o_valid
);

  logic [N-1:0] w_cand;

`ifdef RS_OLDEST_FIRST_EN
  logic [N-1:0][N-1:0] r_older;

  // Newly issued entry becomes younger than every occupied entry; stale
  // bits of freed entries are harmless because they are rewritten on reuse
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_older <= '0;
    end else if (i_flush) begin
      r_older <= '0;
    end else if (i_allocValid) begin
      for (int j = 0; j < N; j++) begin
        r_older[i_allocIdx][j] <= 1'b0;
        r_older[j][i_allocIdx] <= i_busy[j] && (j != int'(i_allocIdx));
      end
    end
  end

  // A ready entry stays a candidate only if no other ready entry is older
  always_comb begin
    w_cand = i_ready;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((j != i) && i_ready[j] && r_older[j][i]) begin
          w_cand[i] = 1'b0;
        end
      end
    end
  end
`else
  assign w_cand = i_ready;
`endif

  // Lowest-index candidate wins; with age ordering exactly one survives
  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        o_index = $clog2(N)'(i);
        o_valid = 1'b1;
      end
    end
    if (o_valid) begin
      o_grant[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds issued instructions until both operands are
// present, snoops the CDB for missing operands and dispatches one ready
// entry per cycle to the functional unit.
// Optional feature: define RS_OLDEST_FIRST_EN for oldest-first dispatch.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int               RS_DEPTH = 8,
  parameter logic [TAG_W-1:0] NO_TAG   = RS_NO_TAG
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_valid_i,
  input  rs_scheduler_s               issue_entry_i,
  input  logic                        cdb_valid_i,
  input  logic [TAG_W-1:0]            cdb_tag_i,
  input  logic [DATA_W-1:0]           cdb_value_i,
  input  logic                        flush_i,
  output logic                        fu_valid_o,
  input  logic                        fu_ready_i,
  output rs_scheduler_s               fu_entry_o,
  output logic                        rs_full_o,
  output logic [$clog2(RS_DEPTH):0]   rs_count_o
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  entry_state_e  r_state     [RS_DEPTH];
  entry_state_e  w_stateNext [RS_DEPTH];
  rs_scheduler_s r_entry     [RS_DEPTH];
  rs_scheduler_s w_entryNext [RS_DEPTH];

  logic [RS_DEPTH-1:0] w_busy;
  logic [RS_DEPTH-1:0] w_ready;
  logic [IDX_W-1:0]    w_freeIdx;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_issueFire;
  logic                w_dispatch;

  logic [RS_DEPTH-1:0] w_arbGrant;
  logic [IDX_W-1:0]    w_arbIdx;
  logic                w_arbValid;
  logic [RS_DEPTH-1:0] w_selGrant;
  logic [IDX_W-1:0]    w_selIdx;
  logic                w_selValid;

  logic                r_lockValid;
  logic [IDX_W-1:0]    r_lockIdx;

  // Occupancy, readiness and first free slot, all from registered state
  always_comb begin
    w_count   = '0;
    w_freeIdx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_busy[i]  = (r_state[i] == ENTRY_BUSY);
      w_ready[i] = w_busy[i] && (r_entry[i].qj == NO_TAG) && (r_entry[i].qk == NO_TAG);
      w_count    = w_count + CNT_W'(w_busy[i]);
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_freeIdx = IDX_W'(i);
      end
    end
  end

  assign w_full      = (w_count == CNT_W'(RS_DEPTH));
  assign rs_full_o   = w_full;
  assign rs_count_o  = w_count;
  assign w_issueFire = issue_valid_i && !w_full && !flush_i;

  rs_select #(
    .N(RS_DEPTH)
  ) u_select (
`ifdef RS_OLDEST_FIRST_EN
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .i_flush     (flush_i),
    .i_allocValid(w_issueFire),
    .i_allocIdx  (w_freeIdx),
    .i_busy      (w_busy),
`endif
    .i_ready     (w_ready),
    .o_grant     (w_arbGrant),
    .o_index     (w_arbIdx),
    .o_valid     (w_arbValid)
  );

  // A stalled dispatch keeps presenting the same entry until it is taken
  always_comb begin
    w_selGrant = '0;
    if (r_lockValid) begin
      w_selIdx             = r_lockIdx;
      w_selValid           = 1'b1;
      w_selGrant[r_lockIdx] = 1'b1;
    end else begin
      w_selIdx   = w_arbIdx;
      w_selValid = w_arbValid;
      w_selGrant = w_arbGrant;
    end
  end

  assign fu_valid_o = w_selValid;
  assign fu_entry_o = w_selValid ? r_entry[w_selIdx] : '0;
  assign w_dispatch = w_selValid && fu_ready_i && !flush_i;

  // Remember the presented entry while the functional unit stalls
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_lockValid <= 1'b0;
      r_lockIdx   <= '0;
    end else begin
      r_lockValid <= w_selValid && !fu_ready_i && !flush_i;
      r_lockIdx   <= w_selIdx;
    end
  end

  // Per-entry next state: flush frees all, otherwise dispatch frees,
  // issue allocates (with same-cycle CDB capture) and busy entries snoop
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_stateNext[i] = r_state[i];
      w_entryNext[i] = w_busy[i]
                     ? cdb_capture(r_entry[i], cdb_valid_i, cdb_tag_i, cdb_value_i, NO_TAG)
                     : r_entry[i];
      if (flush_i) begin
        w_stateNext[i] = ENTRY_FREE;
      end else begin
        if (w_dispatch && w_selGrant[i]) begin
          w_stateNext[i] = ENTRY_FREE;
        end
        if (w_issueFire && (w_freeIdx == IDX_W'(i))) begin
          w_stateNext[i] = ENTRY_BUSY;
          w_entryNext[i] = cdb_capture(issue_entry_i, cdb_valid_i, cdb_tag_i, cdb_value_i, NO_TAG);
        end
      end
    end
  end

  // Entry state and payload registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_state[i] <= ENTRY_FREE;
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_state[i] <= w_stateNext[i];
        r_entry[i] <= w_entryNext[i];
      end
    end
  end

endmodule
